// File: rtl/rv32i_core_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_core_sequencer_pkg
// Shared constants for the multi-cycle rv32i control sequencer: FSM state
// encodings, trap cause codes, the reset-time NOP and the width helper for the
// bus-timeout counter.
// Optional build macro used by the sequencer: CPU_PERF_COUNTERS_EN.
// -----------------------------------------------------------------------------
package rv32i_core_sequencer_pkg;

    // Encodings are externally visible on the state port and must not change.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMemory    = 3'd4,
        StWriteback = 3'd5,
        StTrap      = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        CauseMisalignedFetch = 2'd0,
        CauseReserved        = 2'd1,
        CauseIllegal         = 2'd2,
        CauseBusTimeout      = 2'd3
    } trap_cause_e;

    // addi x0, x0, 0
    localparam logic [31:0] NopInstruction = 32'h0000_0013;

    // Wait-counter width: clog2(limit + 1), never narrower than one bit.
    function automatic int unsigned timeout_cnt_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rv32i_core_sequencer_bus_timeout_counter.sv
// -----------------------------------------------------------------------------
// rv32i_core_sequencer_bus_timeout_counter
// Counts consecutive request cycles that see no ready and flags when the
// current cycle would be the TIMEOUT_CYCLES-th such cycle. TIMEOUT_CYCLES = 0
// disables the timeout (expired is tied low).
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   clear    in   zero the counter (sequencer state is changing)
//   count_en in   request outstanding and ready low this cycle
//   expired  out  this cycle is the last permitted waiting cycle
// -----------------------------------------------------------------------------
module rv32i_core_sequencer_bus_timeout_counter
    import rv32i_core_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CntW = timeout_cnt_width(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // cnt_q holds the number of earlier waiting cycles in this state, so the
    // current waiting cycle is number cnt_q + 1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            localparam logic [CntW-1:0] LastWait = CntW'(TIMEOUT_CYCLES - 1);
            // count_en already excludes ready, so a ready on the limit cycle wins.
            assign expired = count_en && (cnt_q == LastWait);
        end
    endgenerate

endmodule

// File: rtl/rv32i_core_sequencer.sv
// -----------------------------------------------------------------------------
// rv32i_core_sequencer
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller for the rv32i
// core. Owns the PC and instruction registers, drives req/ready handshakes to
// instruction and data memory, retires instructions and traps on misaligned
// fetch, illegal instruction or bus timeout. TRAP is left only by reset.
//
// Optional build macro: CPU_PERF_COUNTERS_EN adds the cycle_count output.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   run                 enable, sampled in IDLE and WRITEBACK
//   imem_*              instruction fetch handshake (word address from pc)
//   dmem_*              data access handshake (word address from alu_result)
//   instruction, pc     registered current instruction / PC
//   pc_next, alu_result, store_data, mem_write_mask,
//   is_load, is_store, rd_write, illegal
//                       decoded control and datapath values
//   load_data           registered load data
//   rd_we               register-file write strobe (WRITEBACK only)
//   state               current FSM state
//   trap, trap_cause    trap flag and cause
//   cycle_count         active-cycle counter (CPU_PERF_COUNTERS_EN only)
//   instret             retired-instruction count
// -----------------------------------------------------------------------------
module rv32i_core_sequencer
    import rv32i_core_sequencer_pkg::*;
#(
    parameter int unsigned IMEM_WIDTH     = 16,
    parameter int unsigned DMEM_WIDTH     = 16,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic                  imem_req,
    output logic [IMEM_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic                  dmem_req,
    output logic [DMEM_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_we,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [31:0]           dmem_rdata,
    output logic [31:0]           instruction,
    output logic [31:0]           pc,
    input  logic [31:0]           pc_next,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           store_data,
    input  logic [3:0]            mem_write_mask,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic                  rd_write,
    input  logic                  illegal,
    output logic [31:0]           load_data,
    output logic                  rd_we,
    output logic [2:0]            state,
    output logic                  trap,
    output logic [1:0]            trap_cause,
`ifdef CPU_PERF_COUNTERS_EN
    output logic [63:0]           cycle_count,
`endif
    output logic [31:0]           instret
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] instret_q, instret_d;
    trap_cause_e cause_q, cause_d;

    logic fetch_aligned;
    logic wait_count_en;
    logic wait_clear;
    logic wait_expired;

    assign fetch_aligned = (pc_q[1:0] == 2'b00);

    // A waiting cycle is one with the request up and its ready low.
    assign wait_count_en = ((state_q == StFetch) && fetch_aligned && !imem_ready) ||
                           ((state_q == StMemory) && !dmem_ready);
    assign wait_clear    = (state_d != state_q);

    rv32i_core_sequencer_bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_timeout_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clear),
        .count_en (wait_count_en),
        .expired  (wait_expired)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        load_data_d = load_data_q;
        instret_d   = instret_q;
        cause_d     = cause_q;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (!fetch_aligned) begin
                    state_d = StTrap;
                    cause_d = CauseMisalignedFetch;
                end else if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = StDecode;
                end else if (wait_expired) begin
                    state_d = StTrap;
                    cause_d = CauseBusTimeout;
                end
            end
            StDecode: begin
                if (illegal) begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                state_d = (is_load || is_store) ? StMemory : StWriteback;
            end
            StMemory: begin
                if (dmem_ready) begin
                    if (is_load) begin
                        load_data_d = dmem_rdata;
                    end
                    state_d = StWriteback;
                end else if (wait_expired) begin
                    state_d = StTrap;
                    cause_d = CauseBusTimeout;
                end
            end
            StWriteback: begin
                pc_d      = pc_next;
                instret_d = instret_q + 32'd1;
                state_d   = run ? StFetch : StIdle;
            end
            StTrap: begin
                // Frozen until reset.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            instr_q     <= NopInstruction;
            load_data_q <= 32'd0;
            instret_q   <= 32'd0;
            cause_q     <= CauseMisalignedFetch;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            load_data_q <= load_data_d;
            instret_q   <= instret_d;
            cause_q     <= cause_d;
        end
    end

`ifdef CPU_PERF_COUNTERS_EN
    logic [63:0] cycle_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count_q <= 64'd0;
        end else if ((state_q != StIdle) && (state_q != StTrap)) begin
            cycle_count_q <= cycle_count_q + 64'd1;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

    // Outputs depend on registered state only; ready inputs never reach them.
    assign imem_req    = (state_q == StFetch) && fetch_aligned;
    assign imem_addr   = pc_q[IMEM_WIDTH+1:2];
    assign dmem_req    = (state_q == StMemory);
    assign dmem_addr   = alu_result[DMEM_WIDTH+1:2];
    assign dmem_we     = ((state_q == StMemory) && is_store) ? mem_write_mask : 4'b0000;
    assign dmem_wdata  = store_data;
    assign rd_we       = (state_q == StWriteback) && rd_write;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign load_data   = load_data_q;
    assign state       = state_q;
    assign trap        = (state_q == StTrap);
    assign trap_cause  = cause_q;
    assign instret     = instret_q;

    // Byte-offset and high address bits are not part of the word address.
    logic unused_alu_bits;
    assign unused_alu_bits = ^{alu_result[1:0], alu_result[31:DMEM_WIDTH+2]};

endmodule

// File: tb/tb_rv32i_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rv32i_core_sequencer
// Directed and randomized bench for rv32i_core_sequencer. Expected values come
// from an instruction-level model: per-instruction cycle counts derived from
// the memory latencies, plus architectural PC / instret / load_data tracking.
// -----------------------------------------------------------------------------
module tb_rv32i_core_sequencer;

    localparam logic [31:0] ResetPc = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic [15:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [3:0]  mem_write_mask;
    logic        is_load;
    logic        is_store;
    logic        rd_write;
    logic        illegal;
    logic [31:0] load_data;
    logic        rd_we;
    logic [2:0]  state;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
`ifdef CPU_PERF_COUNTERS_EN
    logic [63:0] cycle_count;
`endif

    rv32i_core_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .dmem_req       (dmem_req),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .instruction    (instruction),
        .pc             (pc),
        .pc_next        (pc_next),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .mem_write_mask (mem_write_mask),
        .is_load        (is_load),
        .is_store       (is_store),
        .rd_write       (rd_write),
        .illegal        (illegal),
        .load_data      (load_data),
        .rd_we          (rd_we),
        .state          (state),
        .trap           (trap),
        .trap_cause     (trap_cause),
`ifdef CPU_PERF_COUNTERS_EN
        .cycle_count    (cycle_count),
`endif
        .instret        (instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural model
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_load_data;
    logic [31:0] m_instr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        run            = 1'b0;
        imem_ready     = 1'b0;
        dmem_ready     = 1'b0;
        illegal        = 1'b0;
        is_load        = 1'b0;
        is_store       = 1'b0;
        rd_write       = 1'b0;
        repeat (2) @(negedge clk);
        reset       = 1'b1;
        m_pc        = ResetPc;
        m_instret   = 32'd0;
        m_load_data = 32'd0;
        m_instr     = 32'h0000_0013;
    endtask

    // Runs one instruction from FETCH (or IDLE) through WRITEBACK.
    // kind: 0 = ALU, 1 = load, 2 = store. ilat/dlat = ready delay in req cycles.
    task automatic do_instr(input int ilat, input int dlat, input int kind, input bit rdw,
                            input logic [31:0] pcn, input bit run_wb,
                            input logic [31:0] irdata, input logic [31:0] drdata,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [3:0] mask, input string tag,
                            output logic [31:0] seq, output logic [15:0] first_daddr,
                            output logic [3:0] first_we);
        int cyc = 0, ireq = 0, dreq = 0, rdwe = 0, bad = 0, exp_cyc;
        bit done = 0;
        logic [3:0] exp_we;
        seq = 32'd0;
        first_daddr = 16'hxxxx;
        first_we = 4'hx;
        exp_we = (kind == 2) ? mask : 4'b0000;
        if (state == 3'd0) begin
            run = 1'b1;
            @(negedge clk);
        end
        chk({tag, ".start_fetch"}, 64'(state), 64'd1);
        is_load        = (kind == 1);
        is_store       = (kind == 2);
        rd_write       = rdw;
        illegal        = 1'b0;
        pc_next        = pcn;
        alu_result     = addr;
        store_data     = sdata;
        mem_write_mask = mask;
        imem_rdata     = irdata;
        dmem_rdata     = drdata;
        run            = 1'b1;
        while (!done && cyc < 1000) begin
            cyc++;
            seq = {seq[27:0], 1'b0, state};
            // Readies outside their request state are noise the DUT must ignore.
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            if (imem_req) begin
                if (imem_addr !== m_pc[17:2]) bad++;
                imem_ready = (ireq == ilat);
                ireq++;
            end
            if (dmem_req) begin
                if (dreq == 0) begin
                    first_daddr = dmem_addr;
                    first_we    = dmem_we;
                end
                if (dmem_addr !== addr[17:2] || dmem_we !== exp_we || dmem_wdata !== sdata) bad++;
                dmem_ready = (dreq == dlat);
                dreq++;
            end
            if (rd_we) rdwe++;
            if (state == 3'd5) begin
                if (kind == 1) m_load_data = drdata;
                chk({tag, ".load_data_wb"}, 64'(load_data), 64'(m_load_data));
                run  = run_wb;
                done = 1;
            end
            @(negedge clk);
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        seq = {seq[27:0], 1'b0, state};
        exp_cyc = (ilat + 1) + 2 + ((kind != 0) ? (dlat + 1) : 0) + 1;
        m_pc      = pcn;
        m_instret = m_instret + 32'd1;
        m_instr   = irdata;
        chk({tag, ".reached_wb"}, 64'(done), 64'd1);
        chk({tag, ".cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, ".imem_req_cycles"}, 64'(ireq), 64'(ilat + 1));
        chk({tag, ".dmem_req_cycles"}, 64'(dreq), 64'((kind != 0) ? (dlat + 1) : 0));
        chk({tag, ".rd_we_cycles"}, 64'(rdwe), 64'(rdw));
        chk({tag, ".bus_stable"}, 64'(bad), 64'd0);
        chk({tag, ".pc"}, 64'(pc), 64'(m_pc));
        chk({tag, ".instret"}, 64'(instret), 64'(m_instret));
        chk({tag, ".instruction"}, 64'(instruction), 64'(m_instr));
        chk({tag, ".next_state"}, 64'(state), run_wb ? 64'd1 : 64'd0);
    endtask

    initial begin
        logic [31:0] seq;
        logic [15:0] fda;
        logic [3:0]  fwe;
        logic [31:0] r;
        int          n;

        pc_next        = 32'd0;
        alu_result     = 32'd0;
        store_data     = 32'd0;
        mem_write_mask = 4'd0;
        imem_rdata     = 32'd0;
        dmem_rdata     = 32'd0;

        // Reset state
        do_reset();
        chk("rst.state", 64'(state), 64'd0);
        chk("rst.pc", 64'(pc), 64'(ResetPc));
        chk("rst.instruction", 64'(instruction), 64'h13);
        chk("rst.load_data", 64'(load_data), 64'd0);
        chk("rst.instret", 64'(instret), 64'd0);
        chk("rst.trap", 64'({trap, trap_cause}), 64'd0);
        chk("rst.strobes", 64'({imem_req, dmem_req, dmem_we, rd_we}), 64'd0);
`ifdef CPU_PERF_COUNTERS_EN
        chk("rst.cycle_count", cycle_count, 64'd0);
`endif

        // run=0 holds IDLE
        repeat (3) @(negedge clk);
        chk("idle.hold", 64'({state, imem_req}), 64'd0);

        // ADDI, ready every cycle: 1,2,3,5 then back to 1
        do_instr(0, 0, 0, 1'b1, 32'h4, 1'b1, 32'h0010_0093, 32'h0, 32'h0, 32'h0, 4'h0,
                 "addi", seq, fda, fwe);
        chk("addi.state_seq", 64'(seq), 64'h12351);

        // Load with dmem_ready delayed by 3 cycles
        do_instr(0, 3, 1, 1'b1, 32'h8, 1'b1, 32'h0000_2083, 32'hDEAD_BEEF, 32'h0000_0200,
                 32'h0, 4'hF, "load", seq, fda, fwe);
        chk("load.we", 64'(fwe), 64'd0);
        chk("load.load_data", 64'(load_data), 64'hDEAD_BEEF);

        // Store, half-word mask, no rd write
        do_instr(1, 2, 2, 1'b0, 32'hC, 1'b1, 32'h0020_9423, 32'h1234_5678, 32'h0000_0108,
                 32'hCAFE_F00D, 4'b0011, "store", seq, fda, fwe);
        chk("store.addr", 64'(fda), 64'h0042);
        chk("store.we", 64'(fwe), 64'b0011);

        // run=0 sampled at WRITEBACK returns to IDLE
        do_instr(0, 0, 0, 1'b1, 32'h10, 1'b0, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 4'h0,
                 "run0_wb", seq, fda, fwe);

        // Randomized instruction stream
        for (int i = 0; i < 30; i++) begin
            r = $urandom();
            r[1:0] = 2'b00;
            do_instr($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), r, ($urandom_range(0, 3) != 0),
                     $urandom(), $urandom(), $urandom(), $urandom(),
                     4'($urandom_range(1, 15)), "rand", seq, fda, fwe);
        end

        // Reset during a stalled MEMORY access
        if (state == 3'd0) begin
            run = 1'b1;
            @(negedge clk);
        end
        is_load = 1'b1;
        is_store = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmem.dmem_req_before", 64'({state, dmem_req}), 64'({3'd4, 1'b1}));
        #2 reset = 1'b0;
        #1;
        chk("rstmem.dmem_req_async", 64'(dmem_req), 64'd0);
        chk("rstmem.state", 64'(state), 64'd0);
        chk("rstmem.pc", 64'(pc), 64'(ResetPc));
        @(negedge clk);
        do_reset();

        // Fetch never ready: timeout trap after 255 request cycles
        run = 1'b1;
        @(negedge clk);
        n = 0;
        while (state == 3'd1 && n < 400) begin
            if (imem_req) n++;
            imem_ready = 1'b0;
            @(negedge clk);
        end
        chk("timeout.req_cycles", 64'(n), 64'd255);
        chk("timeout.state", 64'(state), 64'd6);
        chk("timeout.trap", 64'({trap, trap_cause}), 64'({1'b1, 2'd3}));
        chk("timeout.req_dropped", 64'(imem_req), 64'd0);
        imem_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("timeout.sticky", 64'({state, pc, instret}), 64'({3'd6, ResetPc, 32'd0}));
        imem_ready = 1'b0;
        do_reset();

        // Ready on exactly the 255th request cycle wins over the timeout
        do_instr(254, 0, 0, 1'b1, 32'h4, 1'b1, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 4'h0,
                 "ready_at_limit", seq, fda, fwe);
        chk("ready_at_limit.no_trap", 64'(trap), 64'd0);

        // Misaligned pc_next after a JALR
        do_instr(0, 0, 0, 1'b1, 32'h6, 1'b1, 32'h0000_8067, 32'h0, 32'h0, 32'h0, 4'h0,
                 "jalr", seq, fda, fwe);
        chk("misalign.no_req", 64'(imem_req), 64'd0);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("misalign.trap", 64'({state, trap, trap_cause}), 64'({3'd6, 1'b1, 2'd0}));
        chk("misalign.frozen", 64'({pc, instret}), 64'({32'h6, m_instret}));
        do_reset();

        // Illegal instruction at DECODE
        run = 1'b1;
        @(negedge clk);
        illegal    = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("illegal.decode", 64'({state, instruction}), 64'({3'd2, 32'hFFFF_FFFF}));
        @(negedge clk);
        chk("illegal.trap", 64'({state, trap, trap_cause}), 64'({3'd6, 1'b1, 2'd2}));
        chk("illegal.no_retire", 64'({instret, rd_we}), 64'd0);
        illegal = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
